// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I encodings, control-select codes and FSM/class enums
package riscv_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SR   = 3'b101;

    localparam logic [2:0] WD_ALU   = 3'd0;
    localparam logic [2:0] WD_LOAD  = 3'd1;
    localparam logic [2:0] WD_IMM   = 3'd2;
    localparam logic [2:0] WD_AUIPC = 3'd3;
    localparam logic [2:0] WD_PC4   = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_L, C_S, C_B, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL
    } instr_class_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: classifies an RV32I instruction and decodes its static datapath selects
//   instr_i   : instruction word
//   cls_o     : instruction class (C_ILL for unsupported opcodes)
//   alucode_o : ALU operation, lcode_o : load/store width (funct3)
//   wd_sel_o  : writeback source, alu_src_o : ALU B = imm, pc_src_o : next-PC source
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_t cls_o,
    output logic [3:0]   alucode_o,
    output logic [2:0]   lcode_o,
    output logic [2:0]   wd_sel_o,
    output logic         alu_src_o,
    output logic [1:0]   pc_src_o
);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       unused_bits;

    assign op          = instr_i[6:0];
    assign f3          = instr_i[14:12];
    assign f7b5        = instr_i[30];
    assign unused_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    assign cls_o = op == OP_R     ? C_R     :
                   op == OP_I     ? C_I     :
                   op == OP_L     ? C_L     :
                   op == OP_S     ? C_S     :
                   op == OP_B     ? C_B     :
                   op == OP_LUI   ? C_LUI   :
                   op == OP_AUIPC ? C_AUIPC :
                   op == OP_JAL   ? C_JAL   :
                   op == OP_JALR  ? C_JALR  : C_ILL;

    // For I-type, bit 30 is immediate data except for shifts; only SRAI uses it as funct7[5].
    assign alucode_o = cls_o == C_R ? {f7b5, f3} :
                       cls_o == C_I ? {f3 == F3_SR && f7b5, f3} : ALU_ADD;
    assign lcode_o   = (cls_o == C_L || cls_o == C_S) ? f3 : 3'b000;
    assign wd_sel_o  = cls_o == C_L     ? WD_LOAD  :
                       cls_o == C_LUI   ? WD_IMM   :
                       cls_o == C_AUIPC ? WD_AUIPC :
                       (cls_o == C_JAL || cls_o == C_JALR) ? WD_PC4 : WD_ALU;
    assign alu_src_o = cls_o == C_I || cls_o == C_L || cls_o == C_S || cls_o == C_JALR;
    assign pc_src_o  = cls_o == C_B ? PC_BRANCH :
                       (cls_o == C_JAL || cls_o == C_JALR) ? PC_JUMP : PC_PLUS4;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I multicycle datapath
//   clk, rst      : clock, synchronous active-high reset
//   instr_code    : current instruction, dataReady : data memory access complete
//   pcen, regFileWe, dataWe, dataRe, illegal_instr : per-state strobes
//   alucode, Lcode, wdSrcMuxSel, aluSrcMuxSel, pcSrcMuxSel : static decoded selects
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_code,
    input  logic        dataReady,
    output logic        pcen,
    output logic        regFileWe,
    output logic [3:0]  alucode,
    output logic [2:0]  Lcode,
    output logic [2:0]  wdSrcMuxSel,
    output logic        aluSrcMuxSel,
    output logic [1:0]  pcSrcMuxSel,
    output logic        dataWe,
    output logic        dataRe,
    output logic        illegal_instr
);
    state_t       state_q, state_d;
    instr_class_t cls;
    logic [3:0]   dec_alu;
    logic [2:0]   dec_lcode, dec_wd;
    logic         dec_asrc;
    logic [1:0]   dec_psrc;

    instr_decoder u_dec (
        .instr_i   (instr_code),
        .cls_o     (cls),
        .alucode_o (dec_alu),
        .lcode_o   (dec_lcode),
        .wd_sel_o  (dec_wd),
        .alu_src_o (dec_asrc),
        .pc_src_o  (dec_psrc)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RESET_STATE;
        else     state_q <= state_d;
    end

    assign alucode      = rst ? ALU_ADD  : dec_alu;
    assign Lcode        = rst ? 3'b000   : dec_lcode;
    assign wdSrcMuxSel  = rst ? WD_ALU   : dec_wd;
    assign aluSrcMuxSel = rst ? 1'b0     : dec_asrc;
    assign pcSrcMuxSel  = rst ? PC_PLUS4 : dec_psrc;

    always_comb begin
        state_d       = state_q;
        pcen          = 1'b0;
        regFileWe     = 1'b0;
        dataWe        = 1'b0;
        dataRe        = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: begin
                if (cls == C_L || cls == C_S) begin
                    state_d = MEM;
                end else begin
                    state_d       = FETCH;
                    pcen          = 1'b1;
                    regFileWe     = cls != C_B && cls != C_ILL;
                    illegal_instr = cls == C_ILL;
                end
            end
            MEM: begin
                dataWe = cls == C_S;
                dataRe = cls == C_L;
                if (dataReady) begin
                    state_d = cls == C_L ? WB : FETCH;
                    pcen    = cls == C_S;
                end
            end
            WB: begin
                state_d   = FETCH;
                regFileWe = 1'b1;
                pcen      = 1'b1;
            end
            default: state_d = RESET_STATE;
        endcase
        // Reset wins over whatever the current state would issue, so an aborted access never commits.
        if (rst) begin
            pcen          = 1'b0;
            regFileWe     = 1'b0;
            dataWe        = 1'b0;
            dataRe        = 1'b0;
            illegal_instr = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector-table and scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
    typedef struct packed {
        logic       pc;
        logic       we;
        logic [3:0] alu;
        logic [2:0] lc;
        logic [2:0] wd;
        logic       as;
        logic [1:0] ps;
        logic       dw;
        logic       dr;
        logic       il;
    } out_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        out_t        exp;
    } vec_t;

    localparam logic [31:0] I_ADD  = 32'h002082B3;
    localparam logic [31:0] I_LW   = 32'h00802183;
    localparam logic [31:0] I_SW   = 32'h0030A423;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JALR = 32'h000080E7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [31:0] ins = I_ADD;
    logic        pcen, regFileWe, aluSrcMuxSel, dataWe, dataRe, illegal_instr;
    logic [3:0]  alucode;
    logic [2:0]  Lcode, wdSrcMuxSel;
    logic [1:0]  pcSrcMuxSel;
    out_t        act;

    vec_t vecs[$];
    out_t sb[$];
    int   total = 0;
    int   bad = 0;

    multicycle_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instr_code    (ins),
        .dataReady     (rdy),
        .pcen          (pcen),
        .regFileWe     (regFileWe),
        .alucode       (alucode),
        .Lcode         (Lcode),
        .wdSrcMuxSel   (wdSrcMuxSel),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .pcSrcMuxSel   (pcSrcMuxSel),
        .dataWe        (dataWe),
        .dataRe        (dataRe),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    assign act = {pcen, regFileWe, alucode, Lcode, wdSrcMuxSel, aluSrcMuxSel,
                  pcSrcMuxSel, dataWe, dataRe, illegal_instr};

    function automatic out_t e(int pc, int we, int alu, int lc, int wd, int as, int ps,
                               int dw, int dr, int il);
        out_t o;
        o.pc  = pc != 0;
        o.we  = we != 0;
        o.alu = 4'(alu);
        o.lc  = 3'(lc);
        o.wd  = 3'(wd);
        o.as  = as != 0;
        o.ps  = 2'(ps);
        o.dw  = dw != 0;
        o.dr  = dr != 0;
        o.il  = il != 0;
        return o;
    endfunction

    task automatic add(int r, logic [31:0] i, int d, out_t x);
        vecs.push_back('{r != 0, i, d != 0, x});
    endtask

    // Single-EXECUTE instruction: FETCH, DECODE, then the final EXECUTE cycle.
    task automatic seq3(logic [31:0] i, int alu, int lc, int wd, int as, int ps, int we, int il);
        add(0, i, 0, e(0, 0, alu, lc, wd, as, ps, 0, 0, 0));
        add(0, i, 1, e(0, 0, alu, lc, wd, as, ps, 0, 0, 0));
        add(0, i, 0, e(1, we, alu, lc, wd, as, ps, 0, 0, il));
    endtask

    task automatic chk(string n);
        out_t x;
        x = sb.pop_front();
        total++;
        if (act !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, x);
        end
    endtask

    // Memory access with n stalled MEM cycles; counts strobe cycles until the pcen pulse.
    task automatic mem_stall(logic [31:0] i, bit ld, int n);
        int  cyc;
        int  strb;
        bit  done;
        bit  we_fin;
        @(posedge clk); #1;
        ins = i;
        rdy = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        cyc    = 0;
        strb   = 0;
        done   = 1'b0;
        we_fin = 1'b0;
        while (!done && cyc < 16) begin
            @(posedge clk); #1;
            rdy = cyc >= n;
            @(negedge clk);
            if (ld ? dataRe : dataWe) strb++;
            if (pcen) begin
                done   = 1'b1;
                we_fin = regFileWe;
            end
            cyc++;
        end
        total++;
        if (!done || strb != n + 1 || cyc != (ld ? n + 2 : n + 1) || we_fin != ld) begin
            bad++;
            $display("FAIL stall_%s n=%0d got done=%0d strobes=%0d cycles=%0d we=%0d exp strobes=%0d cycles=%0d we=%0d",
                     ld ? "lw" : "sw", n, done, strb, cyc, we_fin, n + 1, ld ? n + 2 : n + 1, ld);
        end
    endtask

    initial begin
        add(1, I_ADD, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, I_ADD, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seq3(I_ADD, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) add(0, I_LW, 1, e(0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        repeat (2) add(0, I_LW, 0, e(0, 0, 0, 2, 1, 1, 0, 0, 1, 0));
        add(0, I_LW, 1, e(0, 0, 0, 2, 1, 1, 0, 0, 1, 0));
        add(0, I_LW, 0, e(1, 1, 0, 2, 1, 1, 0, 0, 0, 0));
        repeat (3) add(0, I_SW, 0, e(0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
        add(0, I_SW, 1, e(1, 0, 0, 2, 0, 1, 0, 1, 0, 0));
        seq3(I_BEQ, 0, 0, 0, 0, 1, 0, 0);
        seq3(I_JALR, 0, 0, 4, 1, 2, 1, 0);
        repeat (3) add(0, I_LW, 0, e(0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        add(0, I_LW, 0, e(0, 0, 0, 2, 1, 1, 0, 0, 1, 0));
        add(1, I_LW, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seq3(32'h40315093, 13, 0, 0, 1, 0, 1, 0);
        seq3(32'h00315093, 5, 0, 0, 1, 0, 1, 0);
        seq3(32'h40208133, 8, 0, 0, 0, 0, 1, 0);
        seq3(32'hFFF00093, 0, 0, 0, 1, 0, 1, 0);
        seq3(32'h123450B7, 0, 0, 2, 0, 0, 1, 0);
        seq3(32'h00001097, 0, 0, 3, 0, 0, 1, 0);
        seq3(32'h008000EF, 0, 0, 4, 0, 2, 1, 0);
        seq3(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1);
        add(0, I_ADD, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, I_ADD, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, I_ADD, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seq3(I_ADD, 0, 0, 0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst = vecs[i].rst;
            ins = vecs[i].ins;
            rdy = vecs[i].rdy;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            chk($sformatf("vec%0d", i));
        end

        for (int k = 0; k < 3; k++) begin
            mem_stall(I_SW, 1'b0, int'($urandom_range(0, 3)));
            mem_stall(I_LW, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle FSM and instruction decoder that sits directly upstream of the RV32I multicycle datapath.
- Consumes `instr_code` and drives every datapath control input: `pcen`, `regFileWe`, `alucode`, `Lcode`, `wdSrcMuxSel`, `aluSrcMuxSel`, `pcSrcMuxSel`.
- Also drives the data-memory strobes and handshakes with data memory through `dataReady`.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and matches the datapath's operand, immediate, PC-mux and load/store-data pipeline registers.

Parameters:
- RESET_STATE, FETCH, state entered on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- instr_code  in  32  current instruction from instruction memory (combinational on PC).
- dataReady  in  1  data memory has completed the access this cycle.
- pcen  out  1  PC register enable.
- regFileWe  out  1  register file write enable.
- alucode  out  4  ALU operation.
- Lcode  out  3  load/store width code (funct3).
- wdSrcMuxSel  out  3  writeback source: 0 ALU, 1 load data, 2 imm (LUI), 3 branch_Add (AUIPC), 4 PC+4 (JAL/JALR).
- aluSrcMuxSel  out  1  ALU B operand: 0 rs2, 1 imm.
- pcSrcMuxSel  out  2  next PC: 0 PC+4, 1 branch/AUIPC adder, 2 jump.
- dataWe  out  1  data memory write strobe.
- dataRe  out  1  data memory read strobe.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset: synchronous; the state register goes to FETCH on the next clk edge when rst=1. While rst=1, all outputs are forced: pcen, regFileWe, dataWe, dataRe, illegal_instr = 0; all selects = 0; alucode = ADD (0000); Lcode = 000.
- Reset mid-operation (any state) aborts the instruction. No write or pcen is issued in the reset cycle.
- Opcode classes (standard RV32I): R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Any other opcode is ILLEGAL.
- Static selects are decoded combinationally from instr_code in every non-reset state and held for the whole instruction:
  - aluSrcMuxSel = 1 for I, L, S, JALR; otherwise 0.
  - pcSrcMuxSel = 1 for B; 2 for JAL and JALR; otherwise 0.
  - Lcode = funct3 for L and S; otherwise 000.
  - alucode = {funct7[5], funct3} for R. For I: {1, funct3} only when funct3 = 101 and funct7[5] = 1 (SRAI); otherwise {0, funct3}. ADD for all other classes.
  - Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Per-class state sequences. Each state lasts one cycle unless stated; "final" marks the state that asserts pcen = 1 for exactly one cycle.
  - R, I, LUI, AUIPC, JAL, JALR: FETCH -> DECODE -> EXECUTE (final; regFileWe = 1) -> FETCH. 3 cycles.
  - B: FETCH -> DECODE -> EXECUTE (final; regFileWe = 0) -> FETCH. 3 cycles.
  - S: FETCH -> DECODE -> EXECUTE -> MEM -> FETCH.
    - MEM: dataWe = 1 every cycle; MEM holds while dataReady = 0.
    - pcen = 1 only in the MEM cycle where dataReady = 1 (final). 4 cycles when dataReady is already 1.
  - L: FETCH -> DECODE -> EXECUTE -> MEM -> WB -> FETCH.
    - MEM: dataRe = 1; MEM holds while dataReady = 0.
    - WB: final; regFileWe = 1, wdSrcMuxSel = 1. 5 cycles minimum.
  - ILLEGAL: FETCH -> DECODE -> EXECUTE (final; illegal_instr = 1; no writes; pcSrcMuxSel = 0) -> FETCH.
- The state machine ignores dataReady in FETCH, DECODE, EXECUTE and WB.
- regFileWe, dataWe and dataRe are never asserted in FETCH or DECODE.
- pcen is never asserted in the same cycle as rst.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants.
  - alucode constants.
  - funct3 load/store and branch constants.
  - wdSrc and pcSrc select constants.
  - state_t enum (FETCH, DECODE, EXECUTE, MEM, WB).
  - instr_class_t enum.
- One sub-module, instr_decoder (combinational): instr_code -> instr_class_t plus the static selects, alucode and Lcode.
- The top level holds the state register, next-state logic and strobe generation.

Test Plan:
- add x5,x1,x2 (0x002082B3) after reset release -> 3 cycles. In EXECUTE: alucode = 0000, aluSrcMuxSel = 0, wdSrcMuxSel = 0, regFileWe = 1, pcen = 1. pcen = 0 in FETCH and DECODE.
- lw x3,8(x0) (0x00802183) with dataReady = 0 for the first 2 MEM cycles, then 1 -> dataRe high for 3 MEM cycles. Then WB: regFileWe = 1, wdSrcMuxSel = 1, Lcode = 010, pcen = 1. 7 cycles total.
- sw x3,8(x1) (0x0030A423) with dataReady = 1 -> dataWe = 1 and pcen = 1 in the single MEM cycle. regFileWe = 0 throughout. 4 cycles total.
- beq x1,x2,8 (0x00208463) -> pcSrcMuxSel = 1 for the whole instruction, regFileWe = 0, pcen pulse in EXECUTE. Then jalr x1,0(x1) (0x000080E7) -> pcSrcMuxSel = 2, wdSrcMuxSel = 4, aluSrcMuxSel = 1, regFileWe = 1 in EXECUTE.
- rst asserted for 1 cycle while an lw is stalled in MEM -> next cycle is FETCH; dataRe, regFileWe and pcen are 0 in the reset cycle; the subsequent instruction runs normally.
- instr_code = 0xFFFFFFFF -> 3 cycles; illegal_instr = 1 and pcen = 1 in EXECUTE only; regFileWe, dataWe and dataRe stay 0.
